// File: rtl/config_frame_loader_pkg.sv
// Shared definitions for the configuration frame loader: FSM states,
// header field positions and the default session sync word.
package config_frame_loader_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHeader = 3'd1,
    StData   = 3'd2,
    StStrobe = 3'd3,
    StHold   = 3'd4
  } loaderState_e;

  localparam int          DesyncBit          = 31;
  localparam int          HeaderIdMsb        = 15;
  localparam int          HeaderIdLsb        = 8;
  localparam int          ColumnIdWidth      = 8;
  localparam logic [31:0] DefaultSyncPattern = 32'hFAB0_FAB1;

  // States in which the loader takes words from the bitstream.
  function automatic logic isAccepting(input loaderState_e s);
    case (s)
      StIdle, StHeader, StData: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/config_frame_loader_strobe.sv
// One-hot decode of a frame index into the column strobe vector;
// the parent registers the result.
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5
) (
  input  logic [FrameSelectWidth-1:0] frameIndex,
  input  logic                        enable,
  output logic [MaxFramesPerCol-1:0]  strobe
);

  // Exactly one line high when enabled and the index is in range.
  always_comb begin
    strobe = {MaxFramesPerCol{1'b0}};
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (enable && (frameIndex == FrameSelectWidth'(i))) begin
        strobe[i] = 1'b1;
      end else begin
        strobe[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Bitstream-to-frame engine for one fabric column: sync lock, header/data
// decode, and registered FrameData / one-hot FrameStrobe generation.
module config_frame_loader
  import config_frame_loader_pkg::*;
#(
  parameter int          MaxFramesPerCol  = 20,
  parameter int          FrameBitsPerRow  = 32,
  parameter int          FrameSelectWidth = 5,
  parameter logic [7:0]  ColumnID         = 8'd0,
  parameter logic [31:0] SyncPattern      = DefaultSyncPattern
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [31:0]                WordData,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       ConfigActive,
  output logic                       ConfigDone,
  output logic                       AddrError
);

  loaderState_e state, nextState;

  logic                        wordReadyR;
  logic [FrameBitsPerRow-1:0]  frameDataR;
  logic [MaxFramesPerCol-1:0]  strobeR;
  logic                        activeR;
  logic                        doneR;
  logic                        addrErrR;
  logic [ColumnIdWidth-1:0]    hdrIdR;
  logic [FrameSelectWidth-1:0] hdrIdxR;

  logic                        xfer;
  logic                        isSync;
  logic                        isDesync;
  logic                        idMatch;
  logic                        idxInRange;
  logic                        readyNext;
  logic                        loadData;
  logic                        captureHeader;
  logic                        activeNext;
  logic                        doneNext;
  logic                        addrErrNext;
  logic                        strobeEnable;
  logic [MaxFramesPerCol-1:0]  strobeNext;

  // Handshake uses the registered ready, so no input reaches an output.
  assign xfer       = WordValid && wordReadyR;
  assign isSync     = (WordData == SyncPattern);
  assign isDesync   = WordData[DesyncBit];
  assign idMatch    = (hdrIdR == ColumnID);
  assign idxInRange = ({{(32-FrameSelectWidth){1'b0}}, hdrIdxR} < 32'(MaxFramesPerCol));

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      StIdle: begin
        if (xfer && isSync) nextState = StHeader;
        else                nextState = StIdle;
      end
      StHeader: begin
        if (xfer) nextState = isDesync ? StIdle : StData;
        else      nextState = StHeader;
      end
      StData: begin
        if (xfer) nextState = (idMatch && idxInRange) ? StStrobe : StHeader;
        else      nextState = StData;
      end
      StStrobe: nextState = StHold;
      StHold:   nextState = StHeader;
      default:  nextState = StIdle;
    endcase
  end

  // Output logic: next values for every registered output.
  always_comb begin
    readyNext     = isAccepting(nextState);
    strobeEnable  = (nextState == StStrobe);
    loadData      = 1'b0;
    captureHeader = 1'b0;
    activeNext    = activeR;
    doneNext      = 1'b0;
    addrErrNext   = addrErrR;
    case (state)
      StIdle: begin
        if (xfer && isSync) begin
          activeNext  = 1'b1;
          addrErrNext = 1'b0;
        end else begin
          activeNext  = activeR;
          addrErrNext = addrErrR;
        end
      end
      StHeader: begin
        if (xfer && isDesync) begin
          activeNext = 1'b0;
          doneNext   = 1'b1;
        end else if (xfer) begin
          captureHeader = 1'b1;
        end else begin
          captureHeader = 1'b0;
        end
      end
      StData: begin
        // A foreign column is dropped before the index is even considered.
        if (xfer && idMatch && idxInRange) begin
          loadData = 1'b1;
        end else if (xfer && idMatch) begin
          addrErrNext = 1'b1;
        end else begin
          loadData = 1'b0;
        end
      end
      default: begin
        loadData = 1'b0;
      end
    endcase
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .FrameSelectWidth(FrameSelectWidth)
  ) uStrobeDecoder (
    .frameIndex(hdrIdxR),
    .enable    (strobeEnable),
    .strobe    (strobeNext)
  );

  // Output and header-field registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wordReadyR <= 1'b0;
      frameDataR <= {FrameBitsPerRow{1'b0}};
      strobeR    <= {MaxFramesPerCol{1'b0}};
      activeR    <= 1'b0;
      doneR      <= 1'b0;
      addrErrR   <= 1'b0;
      hdrIdR     <= {ColumnIdWidth{1'b0}};
      hdrIdxR    <= {FrameSelectWidth{1'b0}};
    end else begin
      wordReadyR <= readyNext;
      strobeR    <= strobeNext;
      activeR    <= activeNext;
      doneR      <= doneNext;
      addrErrR   <= addrErrNext;
      if (loadData) begin
        frameDataR <= WordData[FrameBitsPerRow-1:0];
      end
      if (captureHeader) begin
        hdrIdR  <= WordData[HeaderIdMsb:HeaderIdLsb];
        hdrIdxR <= WordData[FrameSelectWidth-1:0];
      end
    end
  end

  assign WordReady    = wordReadyR;
  assign FrameData    = frameDataR;
  assign FrameStrobe  = strobeR;
  assign ConfigActive = activeR;
  assign ConfigDone   = doneR;
  assign AddrError    = addrErrR;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed self-checking bench for config_frame_loader.
module tb_config_frame_loader;

  localparam logic [31:0] Sync = 32'hFAB0_FAB1;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] WordData;
  logic        WordValid;
  logic        WordReady;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        ConfigActive;
  logic        ConfigDone;
  logic        AddrError;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          monEn    = 1'b0;
  int          stabViol = 0;
  logic        prevHigh = 1'b0;
  logic [31:0] prevData = 32'h0;
  logic [19:0] strobeLog[$];
  logic [31:0] dataLog[$];
  int          cycLog[$];

  config_frame_loader #(
    .MaxFramesPerCol (20),
    .FrameBitsPerRow (32),
    .FrameSelectWidth(5),
    .ColumnID        (8'd0),
    .SyncPattern     (32'hFAB0_FAB1)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .WordData    (WordData),
    .WordValid   (WordValid),
    .WordReady   (WordReady),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ConfigActive(ConfigActive),
    .ConfigDone  (ConfigDone),
    .AddrError   (AddrError)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Strobe capture and FrameData stability watch.
  always @(negedge CLK) begin
    if (monEn) begin
      if (FrameStrobe != 20'h0) begin
        strobeLog.push_back(FrameStrobe);
        dataLog.push_back(FrameData);
        cycLog.push_back(cyc);
      end
      if (prevHigh && (FrameData !== prevData)) stabViol <= stabViol + 1;
    end
    prevHigh <= (FrameStrobe != 20'h0);
    prevData <= FrameData;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cycles=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

  task automatic putWord(input logic [31:0] w);
    int n;
    n = 0;
    WordData  = w;
    WordValid = 1'b1;
    while ((WordReady !== 1'b1) && (n < 20)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL put_timeout word=%h ready=%b required 1", w, WordReady);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idleBus();
    WordValid = 1'b0;
    WordData  = 32'h0;
  endtask

  task automatic clearLog();
    strobeLog.delete();
    dataLog.delete();
    cycLog.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleBus();
    repeat (3) @(negedge CLK);
    checks++; if (FrameData !== 32'h0)   begin errors++; $display("FAIL rst_data got=%h exp=%h", FrameData, 32'h0); end
    checks++; if (FrameStrobe !== 20'h0) begin errors++; $display("FAIL rst_strobe got=%h exp=%h", FrameStrobe, 20'h0); end
    checks++; if (WordReady !== 1'b0)    begin errors++; $display("FAIL rst_ready got=%b exp=0", WordReady); end
    checks++; if (ConfigActive !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", ConfigActive); end
    checks++; if (ConfigDone !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b exp=0", ConfigDone); end
    checks++; if (AddrError !== 1'b0)    begin errors++; $display("FAIL rst_addrerr got=%b exp=0", AddrError); end
    reset = 1'b0;
    @(negedge CLK);
    checks++; if (WordReady !== 1'b1)    begin errors++; $display("FAIL post_rst_ready got=%b exp=1", WordReady); end
  endtask

  task automatic test_single_frame();
    putWord(Sync);
    checks++; if (ConfigActive !== 1'b1) begin errors++; $display("FAIL sync_active got=%b exp=1", ConfigActive); end
    putWord(32'h0000_0003);
    putWord(32'hDEAD_BEEF);
    idleBus();
    checks++; if (FrameData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got=%h exp=%h", FrameData, 32'hDEAD_BEEF); end
    checks++; if (FrameStrobe !== 20'h00008)  begin errors++; $display("FAIL single_strobe got=%h exp=%h", FrameStrobe, 20'h00008); end
    checks++; if (WordReady !== 1'b0)          begin errors++; $display("FAIL single_ready_strobe got=%b exp=0", WordReady); end
    @(negedge CLK);
    checks++; if (FrameStrobe !== 20'h0)       begin errors++; $display("FAIL single_hold_strobe got=%h exp=0", FrameStrobe); end
    checks++; if (WordReady !== 1'b0)          begin errors++; $display("FAIL single_ready_hold got=%b exp=0", WordReady); end
    checks++; if (FrameData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hold_data got=%h exp=%h", FrameData, 32'hDEAD_BEEF); end
    @(negedge CLK);
    checks++; if (WordReady !== 1'b1)          begin errors++; $display("FAIL single_ready_back got=%b exp=1", WordReady); end
  endtask

  task automatic test_back_to_back();
    clearLog();
    stabViol = 0;
    monEn = 1'b1;
    putWord(32'h0000_0013);
    putWord(32'h1111_2222);
    putWord(32'h0000_0000);
    putWord(32'h3333_4444);
    idleBus();
    repeat (3) @(negedge CLK);
    monEn = 1'b0;
    checks++; if (strobeLog.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", strobeLog.size()); end
    if (strobeLog.size() == 2) begin
      checks++; if (strobeLog[0] !== 20'h80000) begin errors++; $display("FAIL b2b_strobe0 got=%h exp=%h", strobeLog[0], 20'h80000); end
      checks++; if (strobeLog[1] !== 20'h00001) begin errors++; $display("FAIL b2b_strobe1 got=%h exp=%h", strobeLog[1], 20'h00001); end
      checks++; if (cycLog[1] - cycLog[0] != 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", cycLog[1] - cycLog[0]); end
      checks++; if (dataLog[0] !== 32'h1111_2222) begin errors++; $display("FAIL b2b_data0 got=%h exp=%h", dataLog[0], 32'h1111_2222); end
      checks++; if (dataLog[1] !== 32'h3333_4444) begin errors++; $display("FAIL b2b_data1 got=%h exp=%h", dataLog[1], 32'h3333_4444); end
    end
    checks++; if (stabViol != 0) begin errors++; $display("FAIL b2b_stability got=%0d exp=0", stabViol); end
  endtask

  task automatic test_foreign_column();
    clearLog();
    monEn = 1'b1;
    putWord(32'h0000_0503);
    putWord(32'h1234_5678);
    idleBus();
    checks++; if (WordReady !== 1'b1)          begin errors++; $display("FAIL foreign_ready got=%b exp=1", WordReady); end
    checks++; if (FrameData !== 32'h3333_4444) begin errors++; $display("FAIL foreign_data got=%h exp=%h", FrameData, 32'h3333_4444); end
    repeat (2) @(negedge CLK);
    monEn = 1'b0;
    checks++; if (strobeLog.size() != 0) begin errors++; $display("FAIL foreign_strobe got=%0d pulses exp=0", strobeLog.size()); end
  endtask

  task automatic test_addr_error();
    clearLog();
    monEn = 1'b1;
    putWord(32'h0000_0019);
    putWord(32'hCAFE_F00D);
    idleBus();
    checks++; if (AddrError !== 1'b1)          begin errors++; $display("FAIL addr_set got=%b exp=1", AddrError); end
    checks++; if (FrameData !== 32'h3333_4444) begin errors++; $display("FAIL addr_data got=%h exp=%h", FrameData, 32'h3333_4444); end
    repeat (2) @(negedge CLK);
    monEn = 1'b0;
    checks++; if (strobeLog.size() != 0) begin errors++; $display("FAIL addr_strobe got=%0d pulses exp=0", strobeLog.size()); end
    putWord(32'h0000_0001);
    putWord(32'h5555_AAAA);
    idleBus();
    checks++; if (FrameStrobe !== 20'h00002) begin errors++; $display("FAIL addr_next_strobe got=%h exp=%h", FrameStrobe, 20'h00002); end
    checks++; if (AddrError !== 1'b1)        begin errors++; $display("FAIL addr_sticky got=%b exp=1", AddrError); end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_desync();
    putWord(32'h8000_0000);
    idleBus();
    checks++; if (ConfigDone !== 1'b1)   begin errors++; $display("FAIL desync_done got=%b exp=1", ConfigDone); end
    checks++; if (ConfigActive !== 1'b0) begin errors++; $display("FAIL desync_active got=%b exp=0", ConfigActive); end
    checks++; if (AddrError !== 1'b1)    begin errors++; $display("FAIL desync_addr got=%b exp=1", AddrError); end
    @(negedge CLK);
    checks++; if (ConfigDone !== 1'b0)   begin errors++; $display("FAIL desync_pulse got=%b exp=0", ConfigDone); end
    clearLog();
    monEn = 1'b1;
    putWord(32'h0000_0003);
    putWord(32'h9999_9999);
    idleBus();
    repeat (3) @(negedge CLK);
    monEn = 1'b0;
    checks++; if (strobeLog.size() != 0)       begin errors++; $display("FAIL idle_strobe got=%0d pulses exp=0", strobeLog.size()); end
    checks++; if (FrameData !== 32'h5555_AAAA) begin errors++; $display("FAIL idle_data got=%h exp=%h", FrameData, 32'h5555_AAAA); end
    putWord(Sync);
    idleBus();
    checks++; if (AddrError !== 1'b0)    begin errors++; $display("FAIL resync_addr got=%b exp=0", AddrError); end
    checks++; if (ConfigActive !== 1'b1) begin errors++; $display("FAIL resync_active got=%b exp=1", ConfigActive); end
  endtask

  task automatic test_reset_mid_strobe();
    putWord(32'h0000_0005);
    putWord(32'hA5A5_A5A5);
    idleBus();
    checks++; if (FrameStrobe !== 20'h00020) begin errors++; $display("FAIL mid_strobe_pre got=%h exp=%h", FrameStrobe, 20'h00020); end
    reset = 1'b1;
    @(negedge CLK);
    checks++; if (FrameStrobe !== 20'h0) begin errors++; $display("FAIL mid_strobe got=%h exp=0", FrameStrobe); end
    checks++; if (FrameData !== 32'h0)   begin errors++; $display("FAIL mid_data got=%h exp=0", FrameData); end
    checks++; if (ConfigActive !== 1'b0) begin errors++; $display("FAIL mid_active got=%b exp=0", ConfigActive); end
    reset = 1'b0;
    @(negedge CLK);
    clearLog();
    monEn = 1'b1;
    putWord(32'h0000_0002);
    putWord(32'h7777_7777);
    idleBus();
    repeat (3) @(negedge CLK);
    monEn = 1'b0;
    checks++; if (strobeLog.size() != 0) begin errors++; $display("FAIL mid_ignored got=%0d pulses exp=0", strobeLog.size()); end
    checks++; if (FrameData !== 32'h0)   begin errors++; $display("FAIL mid_ignored_data got=%h exp=0", FrameData); end
    putWord(Sync);
    putWord(32'h0000_0004);
    putWord(32'h0F0F_0F0F);
    idleBus();
    checks++; if (FrameStrobe !== 20'h00010)   begin errors++; $display("FAIL recover_strobe got=%h exp=%h", FrameStrobe, 20'h00010); end
    checks++; if (FrameData !== 32'h0F0F_0F0F) begin errors++; $display("FAIL recover_data got=%h exp=%h", FrameData, 32'h0F0F_0F0F); end
  endtask

  initial begin
    reset     = 1'b1;
    WordValid = 1'b0;
    WordData  = 32'h0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_foreign_column();
    test_addr_error();
    test_desync();
    test_reset_mid_strobe();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
